rca64_op_sequencer: RTL and testbench



---
 rtl/rca64_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_rca64_op_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca64_op_sequencer.sv
// Purpose : registers operand pairs onto an external 64-bit ripple-carry adder, waits for the
//           carry chain to settle, then captures sum/carry/overflow and a running accumulator.
// Latency : result captured SETTLE_CYCLES edges after accept; out_valid high the cycle after.
// Backpres: one operation in flight; in_ready low from accept until the result is taken via out_ready.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready           operand handshake; in_a, in_b, in_cin, in_acc (acc as operand A)
//   acc_clr                     single-cycle pulse, reloads accumulator with ACC_RST
//   add_a/add_b/add_cin         registered drive into the adder
//   add_sum/add_cout            adder outputs, sampled at the capture edge
//   out_valid/out_ready         result handshake; out_sum, out_cout, out_ovf (signed overflow)
//   acc                         accumulator value
// Optional: define RCA64_SEQ_SUB_EN to add port in_sub (1 = compute A - B as A + ~B + 1).
module rca64_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [63:0] ACC_RST       = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_cin,
  input  logic        in_acc,
  input  logic        acc_clr,
`ifdef RCA64_SEQ_SUB_EN
  input  logic        in_sub,
`endif
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic        add_cin,
  input  logic [63:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sum,
  output logic        out_cout,
  output logic        out_ovf,
  output logic [63:0] acc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [63:0] r_add_a;
  logic [63:0] r_add_b;
  logic        r_add_cin;
  logic [63:0] r_out_sum;
  logic        r_out_cout;
  logic        r_out_ovf;
  logic [63:0] r_acc;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;
  logic        w_capture;
  logic [63:0] w_op_a;
  logic [63:0] w_op_b;
  logic        w_op_cin;

  // Operand selection at the accept edge; acc here is the pre-clear value.
  always_comb begin
    w_op_a   = in_acc ? r_acc : in_a;
`ifdef RCA64_SEQ_SUB_EN
    w_op_b   = in_sub ? ~in_b : in_b;
    w_op_cin = in_sub ? 1'b1 : in_cin;
`else
    w_op_b   = in_b;
    w_op_cin = in_cin;
`endif
  end

  assign w_accept  = in_valid && w_in_ready;
  assign w_capture = (r_state == SETTLE) && (r_cnt == 4'd0);

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_add_a    <= 64'h0;
      r_add_b    <= 64'h0;
      r_add_cin  <= 1'b0;
      r_out_sum  <= 64'h0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
      r_acc      <= ACC_RST;
    end else begin
      if (w_accept) begin
        r_add_a   <= w_op_a;
        r_add_b   <= w_op_b;
        r_add_cin <= w_op_cin;
        r_cnt     <= CNT_LOAD;
      end else if (r_state == SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_out_sum  <= add_sum;
        r_out_cout <= add_cout;
        // Overflow judged against the registered operands, so it also holds for A + ~B + 1.
        r_out_ovf  <= (r_add_a[63] == r_add_b[63]) && (add_sum[63] != r_add_a[63]);
      end
      // A clear on the capture edge wins over the new result.
      if (acc_clr)        r_acc <= ACC_RST;
      else if (w_capture) r_acc <= add_sum;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign acc       = r_acc;

endmodule

// File: tb/tb_rca64_op_sequencer.sv
// Purpose : randomized self-checking bench for rca64_op_sequencer with a behavioural adder
//           and an arithmetic reference model of sum, carry, overflow and accumulator.
// Stimulus: directed scenarios from the block's use cases followed by random operations.
module tb_rca64_op_sequencer;

  localparam int unsigned S       = 2;
  localparam logic [63:0] ACC_RST = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic        in_acc;
  logic        acc_clr;
`ifdef RCA64_SEQ_SUB_EN
  logic        in_sub;
`endif
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [63:0] acc;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] model_acc;

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational ripple-carry adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'h0, add_cin};

  rca64_op_sequencer #(.SETTLE_CYCLES(S), .ACC_RST(ACC_RST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_acc(in_acc), .acc_clr(acc_clr),
`ifdef RCA64_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .acc(acc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One complete operation: accept, settle, result check, optional backpressure, drain.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic use_acc, input logic sub, input logic clr_accept,
                       input logic clr_cap, input logic junk, input int hold);
    logic [63:0]        aop, bop, exp_sum;
    logic               c, exp_cout, exp_ovf;
    logic [64:0]        full;
    logic signed [65:0] s;
    int                 cyc;

    aop      = use_acc ? model_acc : a;
    bop      = sub ? ~b : b;
    c        = sub ? 1'b1 : cin;
    full     = {1'b0, aop} + {1'b0, bop} + {64'h0, c};
    exp_sum  = full[63:0];
    exp_cout = full[64];
    s        = $signed({aop[63], aop[63], aop}) + $signed({bop[63], bop[63], bop}) + $signed({65'h0, c});
    // Representable in 64-bit signed iff the top three bits agree.
    exp_ovf  = !(s[65] == s[64] && s[64] == s[63]);

    @(negedge clk);
    chk("in_ready_idle", {63'h0, in_ready}, 64'h1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_acc = use_acc; acc_clr = clr_accept;
`ifdef RCA64_SEQ_SUB_EN
    in_sub = sub;
`endif
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0; in_a = rnd64(); in_b = rnd64(); in_cin = $urandom;
    chk("add_a", add_a, aop);
    chk("add_b", add_b, bop);
    chk("add_cin", {63'h0, add_cin}, {63'h0, c});
    chk("in_ready_busy", {63'h0, in_ready}, 64'h0);

    cyc = 0;
    while (!out_valid && cyc < 40) begin
      acc_clr = clr_cap && (cyc == int'(S) - 1);
      @(negedge clk);
      acc_clr = 1'b0;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(S));
    chk("out_sum", out_sum, exp_sum);
    chk("out_cout", {63'h0, out_cout}, {63'h0, exp_cout});
    chk("out_ovf", {63'h0, out_ovf}, {63'h0, exp_ovf});
    model_acc = clr_cap ? ACC_RST : exp_sum;
    chk("acc", acc, model_acc);

    for (int i = 0; i < hold; i++) begin
      if (junk) begin in_valid = 1'b1; in_a = rnd64(); in_acc = 1'b0; end
      @(negedge clk);
      chk("hold_valid", {63'h0, out_valid}, 64'h1);
      chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
      chk("hold_sum", out_sum, exp_sum);
      chk("hold_add_a", add_a, aop);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", {63'h0, out_valid}, 64'h0);
    chk("drain_in_ready", {63'h0, in_ready}, 64'h1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_acc = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b0;
`ifdef RCA64_SEQ_SUB_EN
    in_sub = 1'b0;
`endif
    model_acc = ACC_RST;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_add_a", add_a, 64'h0);
    chk("rst_add_b", add_b, 64'h0);
    chk("rst_add_cin", {63'h0, add_cin}, 64'h0);
    chk("rst_out_sum", out_sum, 64'h0);
    chk("rst_flags", {62'h0, out_cout, out_ovf}, 64'h0);
    chk("rst_acc", acc, ACC_RST);
    rst = 1'b0;

    // Full wrap to zero with carry-out.
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t1_sum", out_sum, 64'h0);
    chk("t1_cout", {63'h0, out_cout}, 64'h1);
    chk("t1_acc", acc, 64'h0);
    // Signed overflow without carry-out.
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_sum", out_sum, 64'h8000_0000_0000_0000);
    chk("t2_ovf", {62'h0, out_cout, out_ovf}, 64'h1);

    // Accumulate 5, 7, 10 after a clear.
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    chk("clr_acc", acc, ACC_RST);
    model_acc = ACC_RST;
    do_op(64'h0, 64'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(64'h0, 64'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(64'h0, 64'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_acc", acc, 64'd22);

    // Backpressure with a competing in_valid.
    do_op(rnd64(), rnd64(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);

    // Clear coinciding with capture, and with an in_acc accept.
    do_op(rnd64(), rnd64(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    do_op(64'h0, 64'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(64'h0, 64'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("clr_accept_acc", acc, 64'd14);

    // Reset during SETTLE.
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'd123; in_b = 64'd456; in_acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", {63'h0, out_valid}, 64'h0);
    chk("t5_in_ready", {63'h0, in_ready}, 64'h1);
    chk("t5_acc", acc, ACC_RST);
    chk("t5_add_a", add_a, 64'h0);
    rst = 1'b0;
    model_acc = ACC_RST;

`ifdef RCA64_SEQ_SUB_EN
    do_op(64'd10, 64'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_sum", out_sum, 64'd7);
    chk("t6_cout", {63'h0, out_cout}, 64'h1);
    do_op(64'd3, 64'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("t6b_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFF9);
    chk("t6b_cout", {63'h0, out_cout}, 64'h0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [63:0] ra, rb;
      logic        rsub;
      ra = rnd64();
      rb = ($urandom_range(0, 3) == 0) ? ~ra : rnd64();
`ifdef RCA64_SEQ_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      do_op(ra, rb, 1'($urandom), 1'($urandom), rsub,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no end expected end");
    $fatal(1);
  end

endmodule
